// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle control sequencer decoding mv/mvi/add/sub/and into
//               register-file, bus and ALU control strobes. The and instruction
//               is enabled by defining SEQ_AND_OP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] instruction,
    output logic [7:0] in_reg,
    output logic [7:0] out_reg,
    output logic       data,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic [1:0] alu_op,
    output logic       done,
    output logic       busy,
    output logic [3:0] curr_state
);

    localparam logic [3:0] c_IDLE = 4'd0;
    localparam logic [3:0] c_T1   = 4'd1;
    localparam logic [3:0] c_T2   = 4'd2;
    localparam logic [3:0] c_T3   = 4'd3;

    localparam logic [2:0] c_OP_MV  = 3'b000;
    localparam logic [2:0] c_OP_MVI = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b011;
    localparam logic [2:0] c_OP_AND = 3'b100;

`ifdef SEQ_AND_OP_EN
    localparam logic c_AND_EN = 1'b1;
`else
    localparam logic c_AND_EN = 1'b0;
`endif

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [8:0] r_ir;

    logic [2:0] w_op;
    logic [7:0] w_rx_oh;
    logic [7:0] w_ry_oh;
    logic       w_is_alu;
    logic [1:0] w_alu_code;

    assign w_op    = r_ir[8:6];
    assign w_rx_oh = 8'd1 << r_ir[5:3];
    assign w_ry_oh = 8'd1 << r_ir[2:0];

    // Only ops that really go through A/G take the three-step path.
    assign w_is_alu = (w_op == c_OP_ADD) || (w_op == c_OP_SUB) ||
                      ((w_op == c_OP_AND) && c_AND_EN);

    always_comb begin
        w_alu_code = 2'b00;
        if (w_op == c_OP_SUB)
            w_alu_code = 2'b01;
        else if ((w_op == c_OP_AND) && c_AND_EN)
            w_alu_code = 2'b10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ir    <= 9'd0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_IDLE) && start)
                r_ir <= instruction;
        end
    end

    always_comb begin
        w_next_state = c_IDLE;
        case (r_state)
            c_IDLE:  w_next_state = start ? c_T1 : c_IDLE;
            c_T1:    w_next_state = w_is_alu ? c_T2 : c_IDLE;
            c_T2:    w_next_state = c_T3;
            c_T3:    w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        in_reg  = 8'd0;
        out_reg = 8'd0;
        data    = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        alu_op  = 2'b00;
        done    = 1'b0;
        case (r_state)
            c_T1: begin
                if (w_op == c_OP_MV) begin
                    out_reg = w_ry_oh;
                    in_reg  = w_rx_oh;
                    done    = 1'b1;
                end else if (w_op == c_OP_MVI) begin
                    data    = 1'b1;
                    in_reg  = w_rx_oh;
                    done    = 1'b1;
                end else if (w_is_alu) begin
                    out_reg = w_rx_oh;
                    Ain     = 1'b1;
                end else begin
                    done    = 1'b1;
                end
            end
            c_T2: begin
                if (w_is_alu) begin
                    out_reg = w_ry_oh;
                    Gin     = 1'b1;
                    alu_op  = w_alu_code;
                end
            end
            c_T3: begin
                if (w_is_alu) begin
                    Gout    = 1'b1;
                    in_reg  = w_rx_oh;
                    done    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy       = (r_state != c_IDLE);
    assign curr_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer against a step-list
//               model built from the instruction semantics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    typedef struct packed {
        logic [7:0] in_reg;
        logic [7:0] out_reg;
        logic       data;
        logic       Ain;
        logic       Gin;
        logic       Gout;
        logic [1:0] alu_op;
        logic       done;
        logic       busy;
        logic [3:0] st;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] instruction;
    logic [7:0] in_reg, out_reg;
    logic       data, Ain, Gin, Gout, done, busy;
    logic [1:0] alu_op;
    logic [3:0] curr_state;

    int    compared   = 0;
    int    mismatched = 0;
    outs_t exp_q[$];
    outs_t obs;
    outs_t idle_exp;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .in_reg(in_reg), .out_reg(out_reg), .data(data), .Ain(Ain),
        .Gin(Gin), .Gout(Gout), .alu_op(alu_op), .done(done),
        .busy(busy), .curr_state(curr_state)
    );

    assign obs = '{in_reg, out_reg, data, Ain, Gin, Gout, alu_op, done, busy, curr_state};

`ifdef SEQ_AND_OP_EN
    localparam bit c_AND_EN = 1'b1;
`else
    localparam bit c_AND_EN = 1'b0;
`endif

    // Expected per-cycle outputs of one instruction, from its latch edge to done.
    function automatic void model(input logic [8:0] ir);
        outs_t e;
        int    op, x, y;
        op = int'(ir[8:6]);
        x  = int'(ir[5:3]);
        y  = int'(ir[2:0]);
        exp_q.delete();
        e = '0; e.busy = 1'b1; e.st = 4'd1;
        if (op == 0) begin
            e.out_reg = 8'(2 ** y); e.in_reg = 8'(2 ** x); e.done = 1'b1;
            exp_q.push_back(e);
        end else if (op == 1) begin
            e.data = 1'b1; e.in_reg = 8'(2 ** x); e.done = 1'b1;
            exp_q.push_back(e);
        end else if (op == 2 || op == 3 || (op == 4 && c_AND_EN)) begin
            e.out_reg = 8'(2 ** x); e.Ain = 1'b1;
            exp_q.push_back(e);
            e = '0; e.busy = 1'b1; e.st = 4'd2;
            e.out_reg = 8'(2 ** y); e.Gin = 1'b1; e.alu_op = 2'(op - 2);
            exp_q.push_back(e);
            e = '0; e.busy = 1'b1; e.st = 4'd3;
            e.Gout = 1'b1; e.in_reg = 8'(2 ** x); e.done = 1'b1;
            exp_q.push_back(e);
        end else begin
            e.done = 1'b1;
            exp_q.push_back(e);
        end
    endfunction

    // Present an instruction for one accepting edge, then scramble the input.
    task automatic issue(input logic [8:0] ins, input logic hold);
        @(posedge clk); #1;
        start = 1'b1; instruction = ins;
        @(posedge clk); #1;
        start = hold; instruction = 9'($urandom);
    endtask

    task automatic test_reset;
        @(posedge clk); @(posedge clk); @(negedge clk);
        compared++;
        if (obs !== idle_exp) begin
            mismatched++;
            $display("FAIL reset_state: got %h expected %h", obs, idle_exp);
        end
        // First start must be taken on the first edge after release.
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1; instruction = 9'b001_011_000;
        model(9'b001_011_000);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        compared++;
        if (obs !== exp_q[0]) begin
            mismatched++;
            $display("FAIL reset_first_start: got %h expected %h", obs, exp_q[0]);
        end
        @(negedge clk);
        compared++;
        if (obs !== idle_exp) begin
            mismatched++;
            $display("FAIL reset_first_idle: got %h expected %h", obs, idle_exp);
        end
    endtask

    task automatic test_directed;
        logic [8:0] list [6];
        list = '{9'b001_011_000, 9'b000_001_110, 9'b011_000_101,
                 9'b010_010_010, 9'b100_110_001, 9'b111_101_010};
        for (int k = 0; k < 6; k++) begin
            model(list[k]);
            issue(list[k], 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                compared++;
                if (obs !== exp_q[i]) begin
                    mismatched++;
                    $display("FAIL directed_%b step%0d: got %h expected %h", list[k], i, obs, exp_q[i]);
                end
            end
            @(negedge clk);
            compared++;
            if (obs !== idle_exp) begin
                mismatched++;
                $display("FAIL directed_%b idle: got %h expected %h", list[k], obs, idle_exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        int dones = 0;
        model(9'b010_101_011);
        issue(9'b010_101_011, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            dones += int'(done);
            compared++;
            if (obs !== exp_q[i]) begin
                mismatched++;
                $display("FAIL b2b_add step%0d: got %h expected %h", i, obs, exp_q[i]);
            end
        end
        @(negedge clk);
        dones += int'(done);
        compared++;
        if (obs !== idle_exp) begin
            mismatched++;
            $display("FAIL b2b_idle: got %h expected %h", obs, idle_exp);
        end
        compared++;
        if (dones != 1) begin
            mismatched++;
            $display("FAIL b2b_done_count: got %0d expected 1", dones);
        end
        instruction = 9'b000_100_001;
        model(9'b000_100_001);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        compared++;
        if (obs !== exp_q[0]) begin
            mismatched++;
            $display("FAIL b2b_next_accept: got %h expected %h", obs, exp_q[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        issue(9'b010_001_010, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        compared++;
        if (obs !== idle_exp) begin
            mismatched++;
            $display("FAIL reset_mid_async: got %h expected %h", obs, idle_exp);
        end
        repeat (3) begin
            @(negedge clk);
            dones += int'(done);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        dones += int'(done);
        compared++;
        if (dones != 0 || obs !== idle_exp) begin
            mismatched++;
            $display("FAIL reset_mid_abandon: got %h dones=%0d expected %h dones=0", obs, dones, idle_exp);
        end
    endtask

    task automatic test_random;
        logic [8:0] ins;
        logic       hold;
        repeat (40) begin
            ins  = 9'($urandom);
            hold = 1'($urandom);
            model(ins);
            issue(ins, hold);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                compared++;
                if (obs !== exp_q[i]) begin
                    mismatched++;
                    $display("FAIL random_%b step%0d: got %h expected %h", ins, i, obs, exp_q[i]);
                end
            end
            @(negedge clk);
            start = 1'b0;
            compared++;
            if (obs !== idle_exp) begin
                mismatched++;
                $display("FAIL random_%b idle: got %h expected %h", ins, obs, idle_exp);
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                compared++;
                if (obs !== idle_exp) begin
                    mismatched++;
                    $display("FAIL random_gap: got %h expected %h", obs, idle_exp);
                end
            end
        end
    endtask

    initial begin
        idle_exp    = '0;
        rst         = 1'b1;
        start       = 1'b0;
        instruction = 9'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
